// File: rtl/combo_pkg.sv
// combo_pkg: shared encodings, client indices, FSM state and operand
// bundle for the combo_arb arbiter and its combo unit.
package combo_pkg;

  typedef enum logic [1:0] {
    MUX  = 2'b00,
    ENC  = 2'b01,
    DEC  = 2'b10,
    NONE = 2'b11
  } choice_t;

  localparam logic [1:0] CL_MUX = 2'd0;
  localparam logic [1:0] CL_ENC = 2'd1;
  localparam logic [1:0] CL_DEC = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] mux;
    logic [3:0] enc;
    logic [1:0] dec;
  } opnd_t;

  // First requesting client found scanning start, start+1, ... mod 3.
  function automatic logic [1:0] pick(
    input logic [2:0] req,
    input logic [1:0] start
  );
    logic       found;
    logic [1:0] idx;
    found = 1'b0;
    pick  = CL_MUX;
    idx   = start;
    for (int i = 0; i < 3; i++) begin
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
  endfunction

endpackage

// File: rtl/combo_unit.sv
// combo_unit: shared 2:1 mux / 4:2 encoder / 2:4 decoder, result packed
// to 4 bits. Ports: choice, mux_op {sel,I0,I1}, enc_op, dec_op -> y.
module combo_unit
  import combo_pkg::*;
(
  input  logic [1:0] choice,
  input  logic [2:0] mux_op,
  input  logic [3:0] enc_op,
  input  logic [1:0] dec_op,
  output logic [3:0] y
);

  logic       mux_out;
  logic [1:0] enc_out;
  logic [3:0] dec_out;

  assign mux_out = mux_op[2] ? mux_op[0] : mux_op[1];

  // OR-form encoder: exact for one-hot input, no validation otherwise.
  assign enc_out = {enc_op[3] | enc_op[2],
                    enc_op[3] | enc_op[1]};

  assign dec_out = 4'b0001 << dec_op;

  always_comb begin
    y = 4'b0000;
    unique case (1'b1)
      (choice == MUX):  y = {3'b000, mux_out};
      (choice == ENC):  y = {2'b00, enc_out};
      (choice == DEC):  y = dec_out;
      (choice == NONE): y = 4'b0000;
      default:          y = 4'b0000;
    endcase
  end

endmodule

// File: rtl/combo_arb.sv
// combo_arb: 3-client arbiter in front of one shared combo_unit.
// Ports: clk, rst_n (async low); req[2:0] {dec,enc,mux}; mux_op, enc_op,
// dec_op operands; gnt[2:0] one-hot pulse; rsp_valid/rsp_id/rsp_data
// response; busy (not IDLE). Param LAT (1..15) EXEC hold cycles.
// Define COMBO_ARB_RR_EN for round-robin, else fixed bit0>bit1>bit2.
module combo_arb
  import combo_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [2:0] mux_op,
  input  logic [3:0] enc_op,
  input  logic [1:0] dec_op,
  output logic [2:0] gnt,
  output logic       rsp_valid,
  output logic [1:0] rsp_id,
  output logic [3:0] rsp_data,
  output logic       busy
);

  localparam logic [3:0] LAT_W = 4'(LAT);

  state_t     state;
  state_t     nxt;
  logic [2:0] req_q;
  logic [1:0] start;
  logic [1:0] win;
  logic [1:0] win_q;
  logic [3:0] cnt;
  logic       take;
  choice_t    choice_q;
  opnd_t      op_q;
  logic [3:0] unit_y;

`ifdef COMBO_ARB_RR_EN
  logic [1:0] ptr;

  assign start = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= CL_DEC;
    end else if (take) begin
      ptr <= win;
    end
  end
`else
  assign start = CL_MUX;
`endif

  assign win  = pick(req_q, start);
  assign take = (state == IDLE) && (req_q != 3'b000);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (take) nxt = EXEC;
      EXEC:    if (cnt == 4'd1) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // req is registered only on edges that land in IDLE, so requests
  // raised while busy are never seen and the next one is sampled
  // on the very edge that returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= 3'b000;
      gnt      <= 3'b000;
      win_q    <= CL_MUX;
      cnt      <= 4'd0;
      choice_q <= NONE;
      op_q     <= '0;
      rsp_data <= 4'b0000;
    end else begin
      req_q <= (nxt == IDLE) ? req : 3'b000;
      gnt   <= 3'b000;
      if (take) begin
        gnt      <= 3'b001 << win;
        win_q    <= win;
        cnt      <= LAT_W;
        choice_q <= choice_t'(win);
        op_q     <= {mux_op, enc_op, dec_op};
      end else if (state == EXEC) begin
        if (cnt == 4'd1) begin
          rsp_data <= unit_y;
          choice_q <= NONE;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

  combo_unit u_unit (
    .choice (choice_q),
    .mux_op (op_q.mux),
    .enc_op (op_q.enc),
    .dec_op (op_q.dec),
    .y      (unit_y)
  );

  assign rsp_valid = (state == RESP);
  assign rsp_id    = rsp_valid ? win_q : 2'd0;
  assign busy      = (state != IDLE);

endmodule

// File: doc/combo_arb.md
COMBO_ARB -- requirements
Module: combo_arb

Interface
REQ-001 The block SHALL have one parameter: LAT, default 1, EXEC hold cycles per operation, legal range 1..15.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low, with ports named as follows.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
REQ-003 The block SHALL have the following request and operand ports.
- req  in  3  request; bit0 mux client, bit1 encoder client, bit2 decoder client
- mux_op  in  3  {sel,I0,I1} for mux client
- enc_op  in  4  encoder input
- dec_op  in  2  decoder input
REQ-004 The block SHALL have the following grant, response and status ports.
- gnt  out  3  one-hot grant pulse
- rsp_valid  out  1  response strobe
- rsp_id  out  2  client index of response (0/1/2)
- rsp_data  out  4  result
- busy  out  1  high in any state other than IDLE

Function
REQ-005 FSM states SHALL be IDLE, EXEC, RESP; busy SHALL be high in EXEC and RESP.
REQ-006 IDLE SHALL go to EXEC at the edge where req!=0; at that edge:
- winner index captured
- winner operand captured
- LAT counter loaded
REQ-007 gnt SHALL be registered, one-hot, and high only during the first EXEC cycle.
REQ-008 EXEC SHALL hold choice to the unit for exactly LAT cycles, then go to RESP, registering unit output into rsp_data at that edge.
REQ-009 rsp_data packing SHALL be as follows.
- mux: {3'b000,mux_out}
- enc: {2'b00,enc_out}
- dec: dec_out
REQ-010 RESP SHALL last one cycle with rsp_valid=1 and rsp_id=winner, then return to IDLE.
REQ-011 Latency SHALL be as follows.
- req sampled at edge k gives rsp_valid high from edge k+LAT+1 to k+LAT+2
- throughput is one operation per LAT+2 cycles
REQ-012 While idle, choice SHALL be 2'b11, and the unit outputs SHALL be ignored.
REQ-013 Requests arriving while busy SHALL NOT be sampled; a requester SHALL hold req until gnt, and a req dropped before sampling is treated as withdrawn.
REQ-014 Operands SHALL NOT be validated; non-one-hot enc_op passes the unit's result through unchanged.
REQ-015 Operand changes after capture SHALL NOT affect the in-flight result.

Reset
REQ-016 rst_n low SHALL immediately, including mid-operation, apply the following.
- state=IDLE
- gnt=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0
- last-grant pointer=2, so client 0 has top priority first
- in-flight operation discarded with no response
REQ-017 The first request SHALL be sampled at the first rising edge after rst_n deasserts.

Configuration
REQ-018 With COMBO_ARB_RR_EN defined, arbitration SHALL be round-robin:
- search starts at last-grant+1, mod 3
- pointer updates on each grant
REQ-019 Without COMBO_ARB_RR_EN, arbitration SHALL be fixed priority, bit0 > bit1 > bit2, and the pointer logic is absent.

Structure
REQ-020 Shared package combo_pkg SHALL hold:
- choice encodings: MUX=2'b00, ENC=2'b01, DEC=2'b10, NONE=2'b11
- client indices
- FSM state typedef
REQ-021 The existing combo unit SHALL be the one sub-module, instantiated once and driven only by registered choice and operand signals.

Verification
REQ-022 Reset then req=001, mux_op=3'b101, LAT=1 -> gnt=001 one cycle; rsp_valid 2 cycles after the sampling edge; rsp_id=0, rsp_data=4'b0001.
REQ-023 req=100, dec_op=2'b10 -> rsp_id=2, rsp_data=4'b0100; req=010, enc_op=4'b1000 -> rsp_id=1, rsp_data=4'b0011.
REQ-024 req=111 held for 3 operations:
- with RR_EN: grants 001, 010, 100
- without RR_EN: grants 001 each time
REQ-025 LAT=4, single request -> busy high for 5 cycles; rsp_valid edge k+5; operand changed during EXEC does not alter rsp_data.
REQ-026 rst_n pulsed low during EXEC -> all outputs 0 asynchronously; no rsp_valid afterwards; next req=111 is granted 001.
